// File: rtl/mem_arbiter.sv
// Arbiter for the shared instruction/data memory port: picks fetch or load/store,
// runs one transaction at a time through issue, latency-wait and response.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned INST_WIDTH   = 18,
  parameter int unsigned DATA_WIDTH   = 36,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_ack,
  output logic [INST_WIDTH-1:0] o_if_rdata,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  output logic                  o_d_ack,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_busy
);

  localparam int unsigned LAT_W = 2;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;  // 1 = data requester
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic                  if_ack_q, if_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic [INST_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  busy_q, busy_d;
  logic                  grant_d_c;

  // Data wins contention until fetch has been passed over STARVE_LIMIT times.
  assign grant_d_c = i_d_req && !(i_if_req && (starve_q == CNT_W'(STARVE_LIMIT)));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    starve_d   = starve_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (i_if_req || i_d_req) begin
          state_d  = ISSUE;
          owner_d  = grant_d_c;
          mem_en_d = 1'b1;
          if (grant_d_c) begin
            we_d     = i_d_we;
            addr_d   = i_d_addr;
            wdata_d  = i_d_wdata;
            mem_we_d = i_d_we;
            if (i_if_req && (starve_q != CNT_W'(STARVE_LIMIT))) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end else begin
            we_d     = 1'b0;
            addr_d   = i_if_addr;
            wdata_d  = '0;
            starve_d = '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        lat_d   = LAT_W'(MEM_LATENCY - 1);
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = RESP;
          if (owner_q) begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = i_mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = i_mem_rdata[INST_WIDTH-1:0];
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_q      <= '0;
      starve_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign o_if_ack    = if_ack_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_ack     = d_ack_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [13:0] if_addr, d_addr;
  logic [35:0] d_wdata, mem_rdata, mem_rdata3;

  logic        if_ack, d_ack, mem_en, mem_we, busy;
  logic [17:0] if_rdata;
  logic [35:0] d_rdata, mem_wdata;
  logic [13:0] mem_addr;

  logic        if_ack3, d_ack3, mem_en3, mem_we3, busy3;
  logic [17:0] if_rdata3;
  logic [35:0] d_rdata3, mem_wdata3;
  logic [13:0] mem_addr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack), .o_d_rdata(d_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack3), .o_if_rdata(if_rdata3),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack3), .o_d_rdata(d_rdata3),
    .o_mem_en(mem_en3), .o_mem_we(mem_we3), .o_mem_addr(mem_addr3), .o_mem_wdata(mem_wdata3),
    .i_mem_rdata(mem_rdata3), .o_busy(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_rdata3 = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({if_ack, d_ack, mem_en, mem_we, busy, if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_dut1: outputs not zero (en=%b busy=%b addr=%h)", mem_en, busy, mem_addr);
    end
    checks++;
    if ({if_ack3, d_ack3, mem_en3, mem_we3, busy3, if_rdata3, d_rdata3, mem_addr3, mem_wdata3} !== '0) begin
      errors++; $display("FAIL reset_dut3: outputs not zero (en=%b busy=%b addr=%h)", mem_en3, busy3, mem_addr3);
    end
  endtask

  task automatic test_fetch_only();
    do_reset();
    if_req = 1'b1; if_addr = 14'h005;
    tick();  // cycle 1
    checks++;
    if ({mem_en, mem_we, busy, mem_addr} !== {1'b1, 1'b0, 1'b1, 14'h005}) begin
      errors++; $display("FAIL fetch_issue: en=%b we=%b busy=%b addr=%h, expected 1 0 1 005", mem_en, mem_we, busy, mem_addr);
    end
    mem_rdata = 36'hF_FFFF_FFFF;
    tick();  // cycle 2
    mem_rdata = 36'h0_0001_2345;
    checks++;
    if ({mem_en, busy, if_ack} !== 3'b010) begin
      errors++; $display("FAIL fetch_wait: en=%b busy=%b ack=%b, expected 0 1 0", mem_en, busy, if_ack);
    end
    tick();  // cycle 3
    checks++;
    if ({if_ack, d_ack, busy, if_rdata} !== {1'b1, 1'b0, 1'b1, 18'h12345}) begin
      errors++; $display("FAIL fetch_ack: ack=%b dack=%b busy=%b rdata=%h, expected 1 0 1 12345", if_ack, d_ack, busy, if_rdata);
    end
    if_req = 1'b0; mem_rdata = '0;
    tick();  // cycle 4
    checks++;
    if ({if_ack, busy, if_rdata} !== {1'b0, 1'b0, 18'h12345}) begin
      errors++; $display("FAIL fetch_idle: ack=%b busy=%b rdata=%h, expected 0 0 12345", if_ack, busy, if_rdata);
    end
  endtask

  task automatic test_fetch_and_store();
    do_reset();
    if_req = 1'b1; if_addr = 14'h020;
    d_req = 1'b1; d_we = 1'b1; d_addr = 14'h010; d_wdata = 36'hA_BCDE_F012;
    tick();  // cycle 1
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 14'h010, 36'hA_BCDE_F012}) begin
      errors++; $display("FAIL store_issue: en=%b we=%b addr=%h wdata=%h", mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();  // cycle 2
    mem_rdata = 36'h5_5555_5555;
    tick();  // cycle 3
    checks++;
    if ({d_ack, if_ack, d_rdata} !== {1'b1, 1'b0, 36'h0}) begin
      errors++; $display("FAIL store_ack: dack=%b iack=%b drdata=%h, expected 1 0 0", d_ack, if_ack, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0; mem_rdata = '0;
    tick();  // cycle 4
    checks++;
    if ({mem_en, busy, d_ack} !== 3'b000) begin
      errors++; $display("FAIL store_idle: en=%b busy=%b dack=%b, expected 0 0 0", mem_en, busy, d_ack);
    end
    tick();  // cycle 5
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 14'h020}) begin
      errors++; $display("FAIL fetch_after_store: en=%b we=%b addr=%h, expected 1 0 020", mem_en, mem_we, mem_addr);
    end
    tick();  // cycle 6
    mem_rdata = 36'h0_0000_ABCD;
    tick();  // cycle 7
    checks++;
    if ({if_ack, if_rdata, d_rdata} !== {1'b1, 18'h0ABCD, 36'h0}) begin
      errors++; $display("FAIL fetch2_ack: ack=%b irdata=%h drdata=%h", if_ack, if_rdata, d_rdata);
    end
    if_req = 1'b0; mem_rdata = '0;
    tick();
  endtask

  task automatic test_starvation();
    logic [7:0] exp_seq;  // bit i = 1 for data grant
    int         n;
    exp_seq = 8'b0111_0111;
    n = 0;
    do_reset();
    if_req = 1'b1; if_addr = 14'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h200;
    mem_rdata = 36'h9_8765_4321;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      tick();
      if (mem_en) begin
        checks++;
        if (mem_addr !== (exp_seq[n] ? 14'h200 : 14'h100)) begin
          errors++; $display("FAIL starve_grant%0d: addr=%h, expected %h", n, mem_addr, exp_seq[n] ? 14'h200 : 14'h100);
        end
        n++;
      end
    end
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL starve_timeout: saw %0d grants, expected 8", n);
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int cyc = 0; cyc < 10 && busy; cyc++) tick();
    checks++;
    if (busy !== 1'b0 || d_rdata !== 36'h9_8765_4321) begin
      errors++; $display("FAIL starve_drain: busy=%b drdata=%h, expected 0 987654321", busy, d_rdata);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h033;
    tick();  // cycle 1: issue
    tick();  // cycle 2: wait
    rst = 1'b1; d_req = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if ({if_ack, d_ack, mem_en, mem_we, busy, if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_mid: en=%b busy=%b addr=%h drdata=%h irdata=%h", mem_en, busy, mem_addr, d_rdata, if_rdata);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (d_ack || mem_en) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_no_ack: ack or mem_en seen after reset, expected none");
    end
  endtask

  task automatic test_latency3_maxaddr();
    bit early;
    early = 1'b0;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h3FFF;
    tick();  // cycle 1
    mem_rdata3 = 36'hD_EADB_EEF0;
    checks++;
    if ({mem_en3, mem_we3, mem_addr3} !== {1'b1, 1'b0, 14'h3FFF}) begin
      errors++; $display("FAIL lat3_issue: en=%b we=%b addr=%h, expected 1 0 3fff", mem_en3, mem_we3, mem_addr3);
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (d_ack3) early = 1'b1;
      if (c == 4) mem_rdata3 = 36'h8_7654_3210;
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL lat3_early_ack: ack before cycle 5");
    end
    tick();  // cycle 5
    mem_rdata3 = 36'hD_EADB_EEF0;
    checks++;
    if ({d_ack3, if_ack3, d_rdata3} !== {1'b1, 1'b0, 36'h8_7654_3210}) begin
      errors++; $display("FAIL lat3_ack: ack=%b iack=%b drdata=%h, expected 1 0 876543210", d_ack3, if_ack3, d_rdata3);
    end
    d_req = 1'b0;
  endtask

  task automatic test_dropped_request();
    bit extra;
    extra = 1'b0;
    do_reset();
    if_req = 1'b1; if_addr = 14'h077;
    tick();  // cycle 1
    if_req = 1'b0;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 14'h077}) begin
      errors++; $display("FAIL drop_issue: en=%b addr=%h, expected 1 077", mem_en, mem_addr);
    end
    tick();  // cycle 2
    mem_rdata = 36'h0_0003_1111;
    tick();  // cycle 3
    checks++;
    if ({if_ack, if_rdata} !== {1'b1, 18'h31111}) begin
      errors++; $display("FAIL drop_ack: ack=%b rdata=%h, expected 1 31111", if_ack, if_rdata);
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      if (mem_en || busy || if_ack) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++; $display("FAIL drop_idle: activity seen after dropped request completed");
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_fetch_and_store();
    test_starvation();
    test_reset_mid();
    test_latency3_maxaddr();
    test_dropped_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Controls the single unified instruction/data memory port. It arbitrates between the instruction-fetch requester and the load/store requester. It sequences each access through issue, latency-wait and response phases, and returns the read data with a one-cycle ack. It sits between the pipelined datapath (IF and MEM stages) and the memory array. Only one transaction is outstanding at a time.

Parameters:
ADDR_WIDTH, 14, memory word address width (matches PC width)
INST_WIDTH, 18, instruction width; fetch data is i_mem_rdata[INST_WIDTH-1:0]
DATA_WIDTH, 36, memory/data word width
MEM_LATENCY, 1, cycles from the o_mem_en cycle to the i_mem_rdata-valid cycle; legal range 1..4
STARVE_LIMIT, 3, consecutive contested data grants after which fetch is forced to win

Ports:
i_clk  in  1  clock
i_rst  in  1  reset: synchronous, active-high
i_if_req  in  1  fetch request; held until o_if_ack
i_if_addr  in  ADDR_WIDTH  fetch word address
o_if_ack  out  1  one-cycle pulse: fetch complete, o_if_rdata valid
o_if_rdata  out  INST_WIDTH  fetched instruction (registered)
i_d_req  in  1  data request; held until o_d_ack
i_d_we  in  1  1 = store, 0 = load
i_d_addr  in  ADDR_WIDTH  data word address
i_d_wdata  in  DATA_WIDTH  store data
o_d_ack  out  1  one-cycle pulse: data access complete
o_d_rdata  out  DATA_WIDTH  load data (registered)
o_mem_en  out  1  memory access strobe, one cycle per transaction
o_mem_we  out  1  memory write enable, qualified by o_mem_en
o_mem_addr  out  ADDR_WIDTH  memory address
o_mem_wdata  out  DATA_WIDTH  memory write data
i_mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after the o_mem_en cycle
o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: the state goes to IDLE. All outputs, the rdata registers, the latched request and the starvation counter go to 0. An in-flight transaction is dropped and no ack is ever issued for it.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled here.
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner, latch its addr/we/wdata plus an owner bit, and go to ISSUE.
- Arbitration:
  - If only one request is high, it wins.
  - If both are high, data wins unless starve_cnt == STARVE_LIMIT; in that case fetch wins.
- Starvation counter:
  - A data grant while i_if_req is high increments starve_cnt, saturating at STARVE_LIMIT.
  - Any fetch grant clears it.
  - A data grant with i_if_req low leaves it unchanged.
- ISSUE: lasts one cycle.
  - o_mem_en = 1, driving the latched address.
  - o_mem_we = latched we (always 0 for fetch); o_mem_wdata = latched wdata.
  - Go to WAIT with latency counter = MEM_LATENCY-1.
- WAIT:
  - Hold o_mem_en = 0.
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture i_mem_rdata into the owner's rdata register and go to RESP.
  - For MEM_LATENCY = 1, WAIT lasts exactly one cycle.
- RESP: lasts one cycle.
  - Pulse the owner's ack (o_if_ack or o_d_ack); all requests are ignored.
  - Next state is IDLE.
- Latency: a request sampled in IDLE at cycle T gives o_mem_en at T+1 and ack at T+2+MEM_LATENCY.
  - A request held past its ack is treated as a new request in the following IDLE cycle.
  - Back-to-back spacing is therefore MEM_LATENCY+3 cycles.
- Stores: ack timing is the same as for loads. o_d_rdata is NOT updated on a store (it keeps its previous value).
- Requester side effects:
  - Requester inputs that change after the latch point are ignored.
  - A request dropped before its ack still completes, and the ack is still pulsed.
- Data-register stability: o_if_rdata and o_d_rdata change only in the cycle their own ack asserts (or on reset).
- Mutual exclusion: o_if_ack and o_d_ack are never high together, and neither is ever high outside RESP.
- o_mem_en is high for exactly one cycle per transaction.

Test Plan:
1. Fetch only, MEM_LATENCY = 1.
   - Stimulus: i_if_req = 1 at cycle 0, i_if_addr = 0x005; memory returns 0x0_0001_2345 during WAIT.
   - Required: o_mem_en = 1, o_mem_addr = 0x005, o_mem_we = 0 at cycle 1; o_if_ack = 1 and o_if_rdata = 0x12345 at cycle 3; o_busy high during cycles 1-3.
2. Simultaneous fetch and store.
   - Stimulus: i_if_req = i_d_req = 1 at cycle 0; store addr 0x010, wdata 0xA_BCDE_F012.
   - Required: cycle 1 shows o_mem_we = 1, addr 0x010, wdata 0xABCDEF012. o_d_ack pulses at cycle 3 with o_d_rdata unchanged. The fetch is then granted from IDLE at cycle 4, giving o_mem_en at cycle 5.
3. Starvation, STARVE_LIMIT = 3.
   - Stimulus: both requests held continuously, each re-requesting immediately after its ack.
   - Required: grant sequence is D, D, D, IF, D, D, D, IF, with starve_cnt reset after each IF grant.
4. Reset mid-transaction.
   - Stimulus: data load issued; i_rst = 1 for one cycle during WAIT.
   - Required: the next cycle shows the IDLE state, all outputs 0, o_busy = 0. No o_d_ack appears in the 10 following cycles with requests low.
5. MEM_LATENCY = 3, load from addr 0x3FFF (maximum address).
   - Required: o_mem_en at T+1 with addr 0x3FFF. rdata is captured from i_mem_rdata in cycle T+4, the third cycle after the o_mem_en cycle. o_d_ack occurs at T+5.
6. Request dropped early.
   - Stimulus: fetch requested at cycle 0; i_if_req deasserted at cycle 1.
   - Required: the transaction still completes, o_if_ack = 1 at cycle 3, and the arbiter returns to IDLE with no further o_mem_en.
